// File: rtl/pattern_pkg.sv
// pattern_pkg: shared segment glyphs, mode encodings and frame-0 helper
package pattern_pkg;
  localparam logic [7:0] SEG_UP   = 8'b00111001;
  localparam logic [7:0] SEG_DOWN = 8'b11000101;
  localparam logic [7:0] SEG_OFF  = 8'b11111111;
  localparam logic [7:0] SEG_ALL  = 8'b00000000;
  typedef enum logic [1:0] {
    MODE_BOUNCE = 2'd0,
    MODE_CHASE  = 2'd1,
    MODE_FILL   = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_t;
  // True when (pos, phase, level) is the first frame of mode m's sequence.
  function automatic logic is_frame0(mode_t m, logic [1:0] p, logic ph, logic [2:0] l);
    return m == MODE_FILL  ? l == 3'd0 :
           m == MODE_CHASE ? p == 2'd0 :
           m == MODE_BLINK ? !ph : (p == 2'd0 && !ph);
  endfunction
endpackage

// File: rtl/pattern_frame_decode.sv
// pattern_frame_decode: combinational (mode, pos, phase, level) -> four segment bytes
//   mode         : active pattern
//   pos, phase   : lit digit position and up/down glyph select
//   level        : FILL count of lit digits from digit0 upward
//   digit0..3    : active-low segment bytes
module pattern_frame_decode
  import pattern_pkg::*;
(
  input  mode_t       mode,
  input  logic [1:0]  pos,
  input  logic        phase,
  input  logic [2:0]  level,
  output logic [7:0]  digit0,
  output logic [7:0]  digit1,
  output logic [7:0]  digit2,
  output logic [7:0]  digit3
);
  logic [7:0] glyph;
  logic [7:0] seg [4];
  assign glyph = phase ? SEG_DOWN : SEG_UP;
  for (genvar i = 0; i < 4; i++) begin : g_seg
    localparam logic [1:0] IDX = 2'(i);
    assign seg[i] = mode == MODE_FILL  ? (level > 3'(i) ? SEG_ALL : SEG_OFF) :
                    mode == MODE_BLINK ? glyph :
                    pos != IDX         ? SEG_OFF :
                    mode == MODE_CHASE ? SEG_UP : glyph;
  end
  assign digit0 = seg[0];
  assign digit1 = seg[1];
  assign digit2 = seg[2];
  assign digit3 = seg[3];
endmodule

// File: rtl/pattern_sequencer.sv
// pattern_sequencer: multi-mode animation sequencer, one frame per clk_1HZ tick
//   clk_1HZ     : frame clock
//   rst         : synchronous active-high reset
//   pause       : freeze state and outputs
//   mode        : 0=BOUNCE 1=CHASE 2=FILL 3=BLINK
//   digit0..3   : registered active-low segment bytes
//   frame_start : high for the tick that loads frame 0
module pattern_sequencer
  import pattern_pkg::*;
(
  input  logic       clk_1HZ,
  input  logic       rst,
  input  logic       pause,
  input  logic [1:0] mode,
  output logic [7:0] digit0,
  output logic [7:0] digit1,
  output logic [7:0] digit2,
  output logic [7:0] digit3,
  output logic       frame_start
);
  mode_t      mode_q, n_mode;
  logic [1:0] pos, n_pos;
  logic       phase, n_phase;
  logic [2:0] level, n_level;
  // Clear after reset: the first tick only lands on frame 0 instead of advancing.
  logic       primed;
  logic [7:0] d0, d1, d2, d3;
  always_comb begin
    n_mode  = mode_q;
    n_pos   = pos;
    n_phase = phase;
    n_level = level;
    if (!primed || mode_t'(mode) != mode_q) begin
      n_mode  = mode_t'(mode);
      n_pos   = 2'd0;
      n_phase = 1'b0;
      n_level = 3'd0;
    end else begin
      case (mode_q)
        MODE_BOUNCE: begin
          // Turn around at either end: flip phase and keep pos for one frame.
          n_phase = phase ? pos != 2'd0 : pos == 2'd3;
          n_pos   = (phase ? pos == 2'd0 : pos == 2'd3) ? pos :
                    phase ? pos - 2'd1 : pos + 2'd1;
        end
        MODE_CHASE: begin
          n_pos   = pos + 2'd1;
          n_phase = 1'b0;
        end
        MODE_FILL:  n_level = level >= 3'd4 ? 3'd0 : level + 3'd1;
        default:    n_phase = !phase;
      endcase
    end
  end
  // Decode from the next state so the display matches the state loaded this edge.
  pattern_frame_decode u_decode (
    .mode   (n_mode),
    .pos    (n_pos),
    .phase  (n_phase),
    .level  (n_level),
    .digit0 (d0),
    .digit1 (d1),
    .digit2 (d2),
    .digit3 (d3)
  );
  always_ff @(posedge clk_1HZ) begin
    if (rst) begin
      mode_q      <= MODE_BOUNCE;
      pos         <= 2'd0;
      phase       <= 1'b0;
      level       <= 3'd0;
      primed      <= 1'b0;
      digit0      <= SEG_OFF;
      digit1      <= SEG_OFF;
      digit2      <= SEG_OFF;
      digit3      <= SEG_OFF;
      frame_start <= 1'b0;
    end else if (pause) begin
      frame_start <= 1'b0;
    end else begin
      mode_q      <= n_mode;
      pos         <= n_pos;
      phase       <= n_phase;
      level       <= n_level;
      primed      <= 1'b1;
      digit0      <= d0;
      digit1      <= d1;
      digit2      <= d2;
      digit3      <= d3;
      frame_start <= is_frame0(n_mode, n_pos, n_phase, n_level);
    end
  end
endmodule

// File: tb/tb_pattern_sequencer.sv
// tb_pattern_sequencer: scoreboard bench for pattern_sequencer with directed vectors
module tb_pattern_sequencer;
  localparam logic [7:0] U = 8'h39;
  localparam logic [7:0] D = 8'hC5;
  localparam logic [7:0] O = 8'hFF;
  localparam logic [7:0] A = 8'h00;
  typedef struct {
    logic [32:0] v;
    string       name;
  } exp_t;
  logic       clk_1HZ = 1'b0;
  logic       rst = 1'b1;
  logic       pause = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] digit0, digit1, digit2, digit3;
  logic       frame_start;
  exp_t       q[$];
  int         n_tests = 0;
  int         n_fail = 0;
  pattern_sequencer dut (
    .clk_1HZ     (clk_1HZ),
    .rst         (rst),
    .pause       (pause),
    .mode        (mode),
    .digit0      (digit0),
    .digit1      (digit1),
    .digit2      (digit2),
    .digit3      (digit3),
    .frame_start (frame_start)
  );
  always #5 clk_1HZ = ~clk_1HZ;
  task automatic step(input logic r, input logic p, input logic [1:0] m,
                      input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                      input logic [7:0] d, input logic f, input string name);
    exp_t e;
    rst   = r;
    pause = p;
    mode  = m;
    @(posedge clk_1HZ);
    #1;
    e.v    = {a, b, c, d, f};
    e.name = name;
    q.push_back(e);
  endtask
  always @(negedge clk_1HZ) begin
    if (q.size() != 0) begin
      exp_t e;
      logic [32:0] act;
      e   = q.pop_front();
      act = {digit0, digit1, digit2, digit3, frame_start};
      n_tests++;
      if (act !== e.v) begin
        n_fail++;
        $display("FAIL %s: got d0..3=%h %h %h %h fs=%b, expected %h %h %h %h fs=%b",
                 e.name, act[32:25], act[24:17], act[16:9], act[8:1], act[0],
                 e.v[32:25], e.v[24:17], e.v[16:9], e.v[8:1], e.v[0]);
      end
    end
  end
  initial begin
    step(1, 0, 0, O, O, O, O, 0, "reset1");
    step(1, 0, 0, O, O, O, O, 0, "reset2");
    step(0, 0, 0, U, O, O, O, 1, "bounce_f0");
    step(0, 0, 0, O, U, O, O, 0, "bounce_1_0");
    step(0, 0, 0, O, O, U, O, 0, "bounce_2_0");
    step(0, 0, 0, O, O, O, U, 0, "bounce_3_0");
    step(0, 0, 0, O, O, O, D, 0, "bounce_3_1");
    step(0, 0, 0, O, O, D, O, 0, "bounce_2_1");
    step(0, 0, 0, O, D, O, O, 0, "bounce_1_1");
    step(0, 0, 0, D, O, O, O, 0, "bounce_0_1");
    step(0, 0, 0, U, O, O, O, 1, "bounce_wrap");
    step(0, 0, 0, O, U, O, O, 0, "bounce_b_1_0");
    step(0, 0, 0, O, O, U, O, 0, "bounce_b_2_0");
    step(0, 0, 0, O, O, O, U, 0, "bounce_b_3_0");
    step(0, 0, 0, O, O, O, D, 0, "bounce_b_3_1");
    step(0, 0, 0, O, O, D, O, 0, "bounce_b_2_1");
    step(0, 1, 1, O, O, D, O, 0, "pause1");
    step(0, 1, 2, O, O, D, O, 0, "pause2");
    step(0, 1, 3, O, O, D, O, 0, "pause3");
    step(0, 0, 0, O, D, O, O, 0, "pause_release");
    step(0, 0, 2, O, O, O, O, 1, "fill_0");
    step(0, 0, 2, A, O, O, O, 0, "fill_1");
    step(0, 0, 2, A, A, O, O, 0, "fill_2");
    step(0, 0, 2, A, A, A, O, 0, "fill_3");
    step(0, 0, 2, A, A, A, A, 0, "fill_4");
    step(0, 0, 2, O, O, O, O, 1, "fill_wrap");
    step(0, 0, 1, U, O, O, O, 1, "chase_0");
    step(0, 0, 1, O, U, O, O, 0, "chase_1");
    step(0, 0, 1, O, O, U, O, 0, "chase_2");
    step(0, 0, 3, U, U, U, U, 1, "blink_0");
    step(0, 0, 3, D, D, D, D, 0, "blink_1");
    step(1, 0, 3, O, O, O, O, 0, "reset_mid_blink");
    step(0, 0, 3, U, U, U, U, 1, "blink_restart");
    step(0, 0, 3, D, D, D, D, 0, "blink_r1");
    step(0, 0, 3, U, U, U, U, 1, "blink_wrap");
    step(0, 0, 1, U, O, O, O, 1, "chase_b0");
    step(0, 0, 1, O, U, O, O, 0, "chase_b1");
    step(0, 0, 1, O, O, U, O, 0, "chase_b2");
    step(0, 0, 1, O, O, O, U, 0, "chase_b3");
    step(0, 0, 1, U, O, O, O, 1, "chase_wrap");
    step(0, 1, 0, U, O, O, O, 0, "pause_fs_clear");
    for (int i = 0; i < 4 && q.size() != 0; i++) @(posedge clk_1HZ);
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expected frames never checked, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
